// File: rtl/fb_pkg.sv
// Shared frame-buffer definitions: owner tags carried down the access pipeline
// and default bus widths used by the VGA and CPU bus blocks.
package fb_pkg;

    typedef enum logic [1:0] {
        TAG_NONE   = 2'd0,
        TAG_VGA    = 2'd1,
        TAG_CPU_RD = 2'd2,
        TAG_CPU_WR = 2'd3
    } owner_t;

    localparam int FB_ADDR_W = 15;
    localparam int FB_DATA_W = 8;

    function automatic logic is_read(input owner_t tag);
        return (tag == TAG_VGA) || (tag == TAG_CPU_RD);
    endfunction

endpackage

// File: rtl/fb_pipe_stage.sv
// One access-pipeline stage: owner tag plus an opaque payload, cleared
// asynchronously so in-flight accesses vanish on reset.
module fb_pipe_stage
    import fb_pkg::*;
#(
    parameter int PW = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  owner_t        tag_d,
    input  logic [PW-1:0] pay_d,
    output owner_t        tag_q,
    output logic [PW-1:0] pay_q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q <= TAG_NONE;
            pay_q <= '0;
        end else begin
            tag_q <= tag_d;
            pay_q <= pay_d;
        end
    end

endmodule

// File: rtl/fb_arbiter.sv
// Single-port frame-buffer arbiter: VGA has priority, CPU is forced through
// after STARVE_LIMIT waiting cycles; reads return with a fixed 3-cycle latency.
module fb_arbiter
    import fb_pkg::*;
#(
    parameter int ADDR_W       = FB_ADDR_W,
    parameter int DATA_W       = FB_DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_ack,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] vga_rdata,
    input  logic              cpu_valid,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);
    localparam int               S1_W    = 2 + ADDR_W + DATA_W;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    logic [CNT_W-1:0] wait_cnt;
    logic             starved;
    logic             vga_acc_p0;
    logic             cpu_acc_p0;
    owner_t           tag_p0;
    owner_t           tag_p1;
    owner_t           tag_p2;
    logic [S1_W-1:0]  pay_p0;
    logic [S1_W-1:0]  pay_p1;
    logic             rd_p2;
    logic             vga_cap_p2;
    logic             cpu_cap_p2;

    // p0: arbitration and acceptance
    assign starved    = cpu_valid && (wait_cnt == CNT_MAX);
    assign cpu_ready  = rst_n && cpu_valid && (starved || !vga_req);
    assign vga_ack    = rst_n && vga_req && !starved;
    assign vga_acc_p0 = vga_req && vga_ack;
    assign cpu_acc_p0 = cpu_valid && cpu_ready;

    // Payload layout {en, we, addr, wdata} so the RAM strobes come straight off flops.
    always_comb begin
        tag_p0 = TAG_NONE;
        pay_p0 = '0;
        if (vga_acc_p0) begin
            tag_p0 = TAG_VGA;
            pay_p0 = {1'b1, 1'b0, vga_addr, {DATA_W{1'b0}}};
        end else if (cpu_acc_p0) begin
            tag_p0 = cpu_we ? TAG_CPU_WR : TAG_CPU_RD;
            pay_p0 = {1'b1, cpu_we, cpu_addr, cpu_wdata};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (cpu_acc_p0) begin
            wait_cnt <= '0;
        end else if (cpu_valid) begin
            wait_cnt <= sat_inc(wait_cnt);
        end
    end

    // p1: RAM drive
    fb_pipe_stage #(.PW(S1_W)) u_s1 (
        .clk   (clk),
        .rst_n (rst_n),
        .tag_d (tag_p0),
        .pay_d (pay_p0),
        .tag_q (tag_p1),
        .pay_q (pay_p1)
    );

    assign {mem_en, mem_we, mem_addr, mem_wdata} = pay_p1;

    // p2: RAM data returns this cycle, captured into the owner's read register
    fb_pipe_stage #(.PW(1)) u_s2 (
        .clk   (clk),
        .rst_n (rst_n),
        .tag_d (tag_p1),
        .pay_d (is_read(tag_p1)),
        .tag_q (tag_p2),
        .pay_q (rd_p2)
    );

    assign vga_cap_p2 = rd_p2 && (tag_p2 == TAG_VGA);
    assign cpu_cap_p2 = rd_p2 && (tag_p2 == TAG_CPU_RD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_rvalid <= 1'b0;
            cpu_rvalid <= 1'b0;
            vga_rdata  <= '0;
            cpu_rdata  <= '0;
        end else begin
            vga_rvalid <= vga_cap_p2;
            cpu_rvalid <= cpu_cap_p2;
            if (vga_cap_p2) vga_rdata <= mem_rdata;
            if (cpu_cap_p2) cpu_rdata <= mem_rdata;
        end
    end

endmodule

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 Parameters: ADDR_W, default 15, frame-buffer address width; DATA_W, default 8, pixel width; STARVE_LIMIT, default 4, CPU wait cycles before forced CPU grant.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 vga_req  input  1  VGA fetch request, level, held until vga_ack.
REQ-005 vga_addr  input  ADDR_W  VGA fetch address, stable while vga_req.
REQ-006 vga_ack  output  1  VGA request accepted this cycle (combinational).
REQ-007 vga_rvalid  output  1  one-cycle pulse, vga_rdata valid.
REQ-008 vga_rdata  output  DATA_W  VGA pixel, held until next vga_rvalid.
REQ-009 cpu_valid  input  1  CPU request, held until cpu_ready.
REQ-010 cpu_we  input  1  1 = write, 0 = read.
REQ-011 cpu_addr  input  ADDR_W  CPU address.
REQ-012 cpu_wdata  input  DATA_W  CPU write data.
REQ-013 cpu_ready  output  1  CPU request accepted this cycle (combinational).
REQ-014 cpu_rvalid  output  1  one-cycle pulse, cpu_rdata valid (reads only).
REQ-015 cpu_rdata  output  DATA_W  CPU read data, held until next cpu_rvalid.
REQ-016 mem_en, mem_we  output  1 each  registered single-port RAM enable and write enable.
REQ-017 mem_addr  output  ADDR_W  registered RAM address; mem_wdata  output  DATA_W  registered write data.
REQ-018 mem_rdata  input  DATA_W  RAM read data, valid one cycle after mem_en with mem_we=0.

Function
REQ-019 At most one of vga_ack, cpu_ready SHALL be high per cycle; a request is accepted when its valid and ack/ready are both high.
REQ-020 Default priority: VGA; cpu_ready = cpu_valid & !vga_req, unless starved (REQ-022).
REQ-021 Wait counter (width clog2(STARVE_LIMIT+1)) SHALL increment each cycle cpu_valid & !cpu_ready, saturate at STARVE_LIMIT, clear on CPU acceptance.
REQ-022 Counter == STARVE_LIMIT -> CPU SHALL win that cycle even if vga_req; vga_ack low, VGA retried next cycle.
REQ-023 Accept at cycle N -> mem_en/mem_we/mem_addr/mem_wdata driven in cycle N+1; idle cycle -> mem_en=0, mem_we=0.
REQ-024 Read accepted at N -> mem_rdata sampled at end of N+2 into vga_rdata or cpu_rdata; matching rvalid high in cycle N+3; fixed latency 3, one outstanding read per stage.
REQ-025 Pipeline SHALL carry owner tag (NONE/VGA/CPU_RD/CPU_WR) through stages S1 (mem drive) and S2 (data capture); full throughput, one acceptance per cycle.
REQ-026 Accesses SHALL reach RAM in acceptance order; CPU write accepted at N is visible to any read accepted at N+1 or later.
REQ-027 CPU write: no rvalid; completion implied by cpu_ready.
REQ-028 Simultaneous vga_req and cpu_valid, counter below limit: VGA wins, counter increments.
REQ-029 vga_rdata/cpu_rdata SHALL hold last value when no rvalid.

Reset
REQ-030 rst_n low SHALL immediately clear: owner tags to NONE, counter 0, mem_en/mem_we 0, mem_addr/mem_wdata 0, vga_rvalid/cpu_rvalid 0, vga_rdata/cpu_rdata 0.
REQ-031 Reads in flight at reset SHALL be dropped; no rvalid after reset release for them.
REQ-032 vga_ack/cpu_ready SHALL be 0 while rst_n low.

Structure
REQ-033 Shared package fb_pkg: owner-tag enum, ADDR_W/DATA_W defaults; reused by VGA and CPU bus blocks.
REQ-034 One sub-module fb_pipe_stage (tag + address/data register with async clear), instantiated for S1 and S2; arbitration and counter in top level.

Verification
REQ-035 vga_req only, addr 0x03E8, RAM[0x03E8]=0x5A -> vga_ack cycle 0, mem_addr 0x03E8 cycle 1, vga_rvalid with 0x5A cycle 3.
REQ-036 CPU write 0x1234<-0xC3 at cycle 0, CPU read 0x1234 at cycle 1 -> cpu_rvalid cycle 4 with 0xC3.
REQ-037 vga_req held continuously, cpu_valid from cycle 0, STARVE_LIMIT=4 -> cpu_ready cycle 4, vga_ack low cycle 4 only, counter 0 at cycle 5.
REQ-038 Back-to-back VGA reads 0x0000..0x0003 -> four vga_rvalid pulses cycles 3..6, data in order.
REQ-039 rst_n low at cycle 2 after VGA read accepted at cycle 0 -> no vga_rvalid, all outputs zero, normal operation after release.
REQ-040 Both idle 10 cycles -> mem_en 0 throughout, no rvalid, counter 0.
